padframe_seq_ctrl: RTL and testbench

//  Parametrised control layer between the core and a padframe of NUM_PADS bidirectional user pads.

---
 rtl/padframe_seq_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_padframe_seq_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/padframe_seq_ctrl.sv
// padframe_seq_ctrl
//   Control layer between the core and NUM_PADS bidirectional user pads.
//   - Per-pad config (oeb_force, inp_dis, hold) loaded through a serial
//     shift chain into a shadow register, then copied to the active set.
//   - Power-on sequencer releases pads GROUP at a time every STAGGER cycles
//     once the synchronised porb is high, to limit simultaneous switching.
//   - Pad inputs are synchronised; the external reset pad is glitch-filtered.
// Ports
//   clock, resetb           core clock, async active-low reset
//   porb                    async power-on-reset-bar (synchronised here)
//   cfg_shift/sdi/sdo       serial config chain (sdo = chain MSB)
//   cfg_latch               copy shadow chain into active config
//   core_out/core_oeb       core side drive data / output-enable-bar
//   core_in                 synchronised, input-disable-gated pad input
//   pad_out/oeb/inp_dis     registered pad cell controls
//   pad_in                  raw async pad input
//   rst_pad_in              raw reset pad level
//   rst_core_n              filtered reset to core
//   seq_done                all pads released

// One pad: registered output stage plus input synchroniser.
module padframe_seq_ctrl_lane #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       resetb,
  input  logic       en,
  input  logic [2:0] cfg,       // [0] oeb_force, [1] inp_dis, [2] hold
  input  logic       core_out,
  input  logic       core_oeb,
  input  logic       pad_in,
  output logic       pad_out,
  output logic       pad_oeb,
  output logic       pad_inp_dis,
  output logic       core_in
);
  logic [SYNC_STAGES-1:0] sync;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      pad_out     <= 1'b0;
      pad_oeb     <= 1'b1;
      pad_inp_dis <= 1'b1;
    end else if (!en) begin
      // disable wins over hold
      pad_out     <= 1'b0;
      pad_oeb     <= 1'b1;
      pad_inp_dis <= 1'b1;
    end else begin
      pad_inp_dis <= cfg[1];
      if (!cfg[2]) begin
        pad_out <= core_out;
        pad_oeb <= core_oeb | cfg[0];
      end
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) sync <= '0;
    else         sync <= {sync[SYNC_STAGES-2:0], pad_in};
  end

  // gate after the synchroniser so re-enabling shows the current pad level
  assign core_in = sync[SYNC_STAGES-1] & ~pad_inp_dis;
endmodule

module padframe_seq_ctrl #(
  parameter int               NUM_PADS    = 38,
  parameter int               CFG_W       = 3,
  parameter logic [CFG_W-1:0] CFG_RESET   = 3'b011,
  parameter int               GROUP       = 4,
  parameter int               STAGGER     = 8,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILT_CYC    = 16
) (
  input  logic                clock,
  input  logic                resetb,
  input  logic                porb,
  input  logic                cfg_shift,
  input  logic                cfg_sdi,
  output logic                cfg_sdo,
  input  logic                cfg_latch,
  input  logic [NUM_PADS-1:0] core_out,
  input  logic [NUM_PADS-1:0] core_oeb,
  output logic [NUM_PADS-1:0] core_in,
  output logic [NUM_PADS-1:0] pad_out,
  output logic [NUM_PADS-1:0] pad_oeb,
  output logic [NUM_PADS-1:0] pad_inp_dis,
  input  logic [NUM_PADS-1:0] pad_in,
  input  logic                rst_pad_in,
  output logic                rst_core_n,
  output logic                seq_done
);
  localparam int TOTAL = NUM_PADS * CFG_W;
  localparam int EN_W  = $clog2(NUM_PADS + 1);
  localparam int TMR_W = (STAGGER > 1) ? $clog2(STAGGER) : 1;
  localparam int FC_W  = $clog2(FILT_CYC + 1);

  typedef enum logic [1:0] {S_OFF, S_RAMP, S_ON} state_t;

  // ---------------- porb synchroniser ----------------
  logic [1:0] porb_ff;
  logic       porb_sync;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) porb_ff <= '0;
    else         porb_ff <= {porb_ff[0], porb};
  end
  assign porb_sync = porb_ff[1];

  // ---------------- config chain ----------------
  logic [TOTAL-1:0] shadow, active;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      shadow <= {NUM_PADS{CFG_RESET}};
      active <= {NUM_PADS{CFG_RESET}};
    end else begin
      // NBA semantics: a same-cycle shift leaves active with the pre-shift chain
      if (cfg_latch) active <= shadow;
      if (cfg_shift) shadow <= {shadow[TOTAL-2:0], cfg_sdi};
    end
  end
  assign cfg_sdo = shadow[TOTAL-1];

  // ---------------- release sequencer ----------------
  state_t            state;
  logic [EN_W-1:0]   en_cnt;
  logic [TMR_W-1:0]  timer;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state  <= S_OFF;
      en_cnt <= '0;
      timer  <= '0;
    end else if (!porb_sync) begin
      // losing power drops every pad; active config survives
      state  <= S_OFF;
      en_cnt <= '0;
      timer  <= '0;
    end else begin
      case (state)
        S_OFF: begin
          state  <= S_RAMP;
          en_cnt <= '0;
          timer  <= '0;
        end
        S_RAMP: begin
          if (timer == TMR_W'(STAGGER - 1)) begin
            timer <= '0;
            if (int'(en_cnt) + GROUP >= NUM_PADS) begin
              en_cnt <= EN_W'(NUM_PADS);
              state  <= S_ON;
            end else begin
              en_cnt <= en_cnt + EN_W'(GROUP);
            end
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        S_ON:    ;
        default: state <= S_OFF;
      endcase
    end
  end

  // aligned with the pad stage so seq_done rises with the last group's pads
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) seq_done <= 1'b0;
    else         seq_done <= (state == S_ON);
  end

  // ---------------- per-pad lanes ----------------
  for (genvar p = 0; p < NUM_PADS; p++) begin : g_lane
    padframe_seq_ctrl_lane #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clock      (clock),
      .resetb     (resetb),
      .en         (en_cnt > EN_W'(p)),
      .cfg        (active[p*CFG_W +: 3]),
      .core_out   (core_out[p]),
      .core_oeb   (core_oeb[p]),
      .pad_in     (pad_in[p]),
      .pad_out    (pad_out[p]),
      .pad_oeb    (pad_oeb[p]),
      .pad_inp_dis(pad_inp_dis[p]),
      .core_in    (core_in[p])
    );
  end

  // ---------------- reset pad filter ----------------
  logic [1:0]      rst_ff;
  logic            rst_sync;
  logic [FC_W-1:0] filt_cnt;

  assign rst_sync = rst_ff[1];

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      rst_ff     <= '0;
      filt_cnt   <= '0;
      rst_core_n <= 1'b0;
    end else begin
      rst_ff <= {rst_ff[0], rst_pad_in};
      if (rst_sync == rst_core_n) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FC_W'(FILT_CYC - 1)) begin
        // this cycle is the FILT_CYC-th consecutive disagreement
        rst_core_n <= rst_sync;
        filt_cnt   <= '0;
      end else begin
        filt_cnt <= filt_cnt + FC_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_padframe_seq_ctrl.sv
// Bench for padframe_seq_ctrl: directed scenarios then random traffic.
// A reference model advanced once per clock pushes the expected outputs for
// each cycle into a queue; a monitor pops and compares on the falling edge.
module tb_padframe_seq_ctrl;
  localparam int N = 4, W = 3, G = 2, ST = 4, SS = 2, FC = 3, TOT = N * W;

  logic         clock = 1'b0, resetb = 1'b1, porb = 1'b0;
  logic         cfg_shift = 1'b0, cfg_sdi = 1'b0, cfg_latch = 1'b0, rst_pad_in = 1'b0;
  logic [N-1:0] core_out = '0, core_oeb = '0, pad_in = '0;
  logic         cfg_sdo, rst_core_n, seq_done;
  logic [N-1:0] core_in, pad_out, pad_oeb, pad_inp_dis;

  always #5 clock = ~clock;

  padframe_seq_ctrl #(
    .NUM_PADS(N), .CFG_W(W), .CFG_RESET(3'b000), .GROUP(G),
    .STAGGER(ST), .SYNC_STAGES(SS), .FILT_CYC(FC)
  ) dut (
    .clock(clock), .resetb(resetb), .porb(porb),
    .cfg_shift(cfg_shift), .cfg_sdi(cfg_sdi), .cfg_sdo(cfg_sdo), .cfg_latch(cfg_latch),
    .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in),
    .pad_out(pad_out), .pad_oeb(pad_oeb), .pad_inp_dis(pad_inp_dis), .pad_in(pad_in),
    .rst_pad_in(rst_pad_in), .rst_core_n(rst_core_n), .seq_done(seq_done)
  );

  typedef struct {
    logic [N-1:0] out, oeb, dis, cin;
    logic         sdo, rcore, done;
  } exp_t;
  exp_t q[$];

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TOT-1:0] m_shadow, m_act;
  logic [N-1:0]   m_out, m_oeb, m_dis;
  logic [N-1:0]   m_sync [SS];
  logic [1:0]     m_porb_h, m_rs_h;
  logic           m_done, m_rcore;
  int             m_run, m_en, m_rcnt;

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic m_reset();
    m_shadow = '0; m_act = '0;
    m_out = '0; m_oeb = '1; m_dis = '1; m_done = 1'b0;
    m_run = 0; m_en = 0; m_porb_h = '0;
    for (int s = 0; s < SS; s++) m_sync[s] = '0;
    m_rs_h = '0; m_rcore = 1'b0; m_rcnt = 0;
  endtask

  // One clock edge with the inputs currently applied.
  task automatic step_model();
    logic [2:0] c;
    logic       rs;
    for (int p = 0; p < N; p++) begin
      c = m_act[p*W +: 3];
      if (p >= m_en) begin
        m_out[p] = 1'b0; m_oeb[p] = 1'b1; m_dis[p] = 1'b1;
      end else begin
        m_dis[p] = c[1];
        if (!c[2]) begin
          m_out[p] = core_out[p];
          m_oeb[p] = core_oeb[p] | c[0];
        end
      end
    end
    m_done = (m_en == N);
    if (cfg_latch) m_act = m_shadow;
    if (cfg_shift) m_shadow = {m_shadow[TOT-2:0], cfg_sdi};
    // released pads derived from how long synchronised porb has stayed high
    if (m_porb_h[1]) begin
      if (m_run < 1000000) m_run++;
    end else begin
      m_run = 0;
    end
    m_en = (m_run == 0) ? 0 : min2(G * ((m_run - 1) / ST), N);
    m_porb_h = {m_porb_h[0], porb};
    for (int s = SS - 1; s > 0; s--) m_sync[s] = m_sync[s-1];
    m_sync[0] = pad_in;
    rs = m_rs_h[1];
    if (rs == m_rcore) m_rcnt = 0;
    else begin
      m_rcnt++;
      if (m_rcnt == FC) begin m_rcore = rs; m_rcnt = 0; end
    end
    m_rs_h = {m_rs_h[0], rst_pad_in};
  endtask

  task automatic push_exp();
    exp_t e;
    e.out = m_out; e.oeb = m_oeb; e.dis = m_dis;
    e.cin = m_sync[SS-1] & ~m_dis;
    e.sdo = m_shadow[TOT-1]; e.rcore = m_rcore; e.done = m_done;
    q.push_back(e);
  endtask

  // ---------------- monitor ----------------
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pad_out",     32'(pad_out),     32'(e.out));
        chk("sb_pad_oeb",     32'(pad_oeb),     32'(e.oeb));
        chk("sb_pad_inp_dis", 32'(pad_inp_dis), 32'(e.dis));
        chk("sb_core_in",     32'(core_in),     32'(e.cin));
        chk("sb_cfg_sdo",     32'(cfg_sdo),     32'(e.sdo));
        chk("sb_rst_core_n",  32'(rst_core_n),  32'(e.rcore));
        chk("sb_seq_done",    32'(seq_done),    32'(e.done));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    if (!resetb) m_reset();
    else         step_model();
    push_exp();
    #2;
  endtask

  task automatic do_async_reset(input int hold);
    @(negedge clock);
    #1 resetb = 1'b0;
    m_reset();
    #1;
    chk("async_rst_oeb",  32'(pad_oeb),  32'hF);
    chk("async_rst_done", 32'(seq_done), 32'h0);
    repeat (hold) tick();
    resetb = 1'b1;
  endtask

  task automatic shift_bits(input logic [TOT-1:0] bits);
    cfg_shift = 1'b1;
    for (int i = TOT - 1; i >= 0; i--) begin
      cfg_sdi = bits[i];
      tick();
    end
    cfg_shift = 1'b0; cfg_sdi = 1'b0;
  endtask

  task automatic load_cfg(input logic [TOT-1:0] bits);
    shift_bits(bits);
    cfg_latch = 1'b1;
    tick();
    cfg_latch = 1'b0;
  endtask

  // porb rises just before edge 0: group 0 at cycle 7, all pads + done at 11
  task automatic ramp_directed();
    porb = 1'b1;
    repeat (7) tick();
    chk("ramp_c6_oeb", 32'(pad_oeb), 32'hF);
    tick();
    chk("ramp_c7_oeb", 32'(pad_oeb), 32'hC);
    repeat (3) tick();
    chk("ramp_c10_done", 32'(seq_done), 32'h0);
    tick();
    chk("ramp_c11_oeb", 32'(pad_oeb), 32'h0);
    chk("ramp_c11_done", 32'(seq_done), 32'h1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    m_reset();
    #1 resetb = 1'b0;
    repeat (3) tick();
    chk("rst_pad_out",  32'(pad_out),     32'h0);
    chk("rst_pad_oeb",  32'(pad_oeb),     32'hF);
    chk("rst_inp_dis",  32'(pad_inp_dis), 32'hF);
    chk("rst_core_in",  32'(core_in),     32'h0);
    chk("rst_cfg_sdo",  32'(cfg_sdo),     32'h0);
    chk("rst_core_n",   32'(rst_core_n),  32'h0);
    chk("rst_seq_done", 32'(seq_done),    32'h0);
    resetb = 1'b1;
    repeat (2) tick();

    ramp_directed();

    // drop porb after the first group is out, then a full ramp again
    porb = 1'b0;
    repeat (8) tick();
    porb = 1'b1;
    repeat (9) tick();
    chk("midramp_oeb", 32'(pad_oeb), 32'hC);
    porb = 1'b0;
    repeat (4) tick();
    chk("drop_oeb",  32'(pad_oeb),     32'hF);
    chk("drop_dis",  32'(pad_inp_dis), 32'hF);
    chk("drop_done", 32'(seq_done),    32'h0);
    repeat (4) tick();
    ramp_directed();

    // hold on pad 3 freezes its output
    core_out = 4'b1000;
    repeat (2) tick();
    shift_bits(12'h800);
    chk("sdo_first_in", 32'(cfg_sdo), 32'h1);
    cfg_latch = 1'b1;
    tick();
    cfg_latch = 1'b0;
    tick();
    core_out = 4'b0000;
    repeat (3) tick();
    chk("hold_pad_out", 32'(pad_out), 32'h8);
    load_cfg('0);
    repeat (2) tick();

    // latch and shift together: active gets the pre-shift chain
    shift_bits(12'h082);
    cfg_shift = 1'b1; cfg_sdi = 1'b0; cfg_latch = 1'b1;
    tick();
    cfg_shift = 1'b0; cfg_latch = 1'b0;
    tick();
    chk("latch_shift_dis", 32'(pad_inp_dis), 32'h5);
    load_cfg('0);

    // input gating on pad 1
    pad_in = 4'b0010;
    load_cfg(12'h010);
    repeat (3) tick();
    chk("gate_core_in", 32'(core_in), 32'h0);
    load_cfg('0);
    tick();
    chk("ungate_core_in", 32'(core_in), 32'h2);

    // reset pad filter: short glitch rejected, steady level accepted
    rst_pad_in = 1'b1;
    repeat (2) tick();
    rst_pad_in = 1'b0;
    repeat (8) tick();
    chk("filt_glitch", 32'(rst_core_n), 32'h0);
    rst_pad_in = 1'b1;
    repeat (4) tick();
    chk("filt_early", 32'(rst_core_n), 32'h0);
    tick();
    chk("filt_release", 32'(rst_core_n), 32'h1);

    // mid-ramp async reset
    porb = 1'b0;
    repeat (4) tick();
    porb = 1'b1;
    repeat (8) tick();
    do_async_reset(2);

    // random traffic
    for (int i = 0; i < 2000; i++) begin
      core_out  = N'($urandom);
      core_oeb  = N'($urandom);
      pad_in    = N'($urandom);
      cfg_sdi   = 1'($urandom);
      cfg_shift = ($urandom_range(1, 0) == 0);
      cfg_latch = ($urandom_range(7, 0) == 0);
      if (porb ? ($urandom_range(59, 0) == 0) : ($urandom_range(9, 0) == 0)) porb = ~porb;
      if ($urandom_range(5, 0) == 0) rst_pad_in = ~rst_pad_in;
      if ($urandom_range(249, 0) == 0) do_async_reset(2);
      tick();
    end

    cfg_shift = 1'b0; cfg_latch = 1'b0;
    tick();
    @(negedge clock);
    #1;
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
